// File: rtl/legv8_pkg.sv
// Shared encodings for the multicycle LEGv8 controller: states, opcode patterns,
// ALU and SignExtender codes, and the decoded control bundle.
package legv8_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LDUR = 3'd2,
    CLS_STUR = 3'd3,
    CLS_B    = 3'd4,
    CLS_CBZ  = 3'd5
  } class_e;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] SIGN_I  = 2'b00;
  localparam logic [1:0] SIGN_D  = 2'b01;
  localparam logic [1:0] SIGN_B  = 2'b10;
  localparam logic [1:0] SIGN_CB = 2'b11;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b1001000100?;
  localparam logic [10:0] OP_SUBI = 11'b1101000100?;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_B    = 11'b000101?????;
  localparam logic [10:0] OP_CBZ  = 11'b10110100???;

  typedef struct packed {
    class_e      cls;
    logic [1:0]  signOp;
    logic [3:0]  aluOp;
    logic        aluSrc;
    logic        reg2loc;
  } ctrl_t;

endpackage

// File: rtl/legv8_opdecode.sv
// Combinational opcode decoder: maps IR[31:21] to an instruction class and the
// datapath controls that stay fixed for the whole instruction.
module legv8_opdecode
  import legv8_pkg::*;
(
  input  logic [10:0] i_opcode,
  output ctrl_t       o_ctrl,
  output logic        o_illegal
);

  always_comb begin
    o_ctrl         = '0;
    o_ctrl.cls     = CLS_R;
    o_ctrl.signOp  = SIGN_I;
    o_ctrl.aluOp   = ALU_ADD;
    o_ctrl.aluSrc  = 1'b0;
    o_ctrl.reg2loc = 1'b0;
    o_illegal      = 1'b0;
    casez (i_opcode)
      OP_ADD:  o_ctrl.aluOp = ALU_ADD;
      OP_SUB:  o_ctrl.aluOp = ALU_SUB;
      OP_AND:  o_ctrl.aluOp = ALU_AND;
      OP_ORR:  o_ctrl.aluOp = ALU_ORR;
      OP_ADDI: begin
        o_ctrl.cls    = CLS_I;
        o_ctrl.aluSrc = 1'b1;
      end
      OP_SUBI: begin
        o_ctrl.cls    = CLS_I;
        o_ctrl.aluOp  = ALU_SUB;
        o_ctrl.aluSrc = 1'b1;
      end
      OP_LDUR: begin
        o_ctrl.cls    = CLS_LDUR;
        o_ctrl.signOp = SIGN_D;
        o_ctrl.aluSrc = 1'b1;
      end
      OP_STUR: begin
        o_ctrl.cls     = CLS_STUR;
        o_ctrl.signOp  = SIGN_D;
        o_ctrl.aluSrc  = 1'b1;
        o_ctrl.reg2loc = 1'b1;
      end
      OP_B: begin
        o_ctrl.cls    = CLS_B;
        o_ctrl.signOp = SIGN_B;
        o_ctrl.aluOp  = ALU_AND;
      end
      OP_CBZ: begin
        o_ctrl.cls     = CLS_CBZ;
        o_ctrl.signOp  = SIGN_CB;
        o_ctrl.aluOp   = ALU_PASSB;
        o_ctrl.reg2loc = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle LEGv8 datapath (fetch/decode/exec/mem/wb)
// with a memory-wait watchdog and a sticky fault state.
module multicycle_controller
  import legv8_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        imem_valid,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        reg_we,
  output logic        reg2loc,
  output logic        alu_src,
  output logic [3:0]  alu_op,
  output logic [1:0]  sign_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        fault,
  output logic [2:0]  state
);

  state_e      r_state;
  ctrl_t       r_ctrl;
  logic [15:0] r_waitCnt;
  ctrl_t       w_decCtrl;
  logic        w_illegal;
  logic        w_timeout;

  legv8_opdecode u_opdecode (
    .i_opcode  (opcode),
    .o_ctrl    (w_decCtrl),
    .o_illegal (w_illegal)
  );

  // The stall that would bring the count up to MEM_TIMEOUT is the one that faults.
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_waitCnt == 16'(MEM_TIMEOUT - 1));

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state   <= S_FETCH;
      r_ctrl    <= '0;
      r_waitCnt <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_valid) begin
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state <= S_FAULT;
          end else begin
            r_waitCnt <= r_waitCnt + 16'd1;
          end
        end
        S_DECODE: begin
          if (w_illegal) begin
            r_state <= S_FAULT;
          end else begin
            r_ctrl  <= w_decCtrl;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_waitCnt <= '0;
          case (r_ctrl.cls)
            CLS_R, CLS_I:       r_state <= S_WB;
            CLS_LDUR, CLS_STUR: r_state <= S_MEM;
            default:            r_state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            r_waitCnt <= '0;
            r_state   <= (r_ctrl.cls == CLS_LDUR) ? S_WB : S_FETCH;
          end else if (w_timeout) begin
            r_state <= S_FAULT;
          end else begin
            r_waitCnt <= r_waitCnt + 16'd1;
          end
        end
        S_WB: begin
          r_waitCnt <= '0;
          r_state   <= S_FETCH;
        end
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_FAULT;
      endcase
    end
  end

  // Strobes follow the registered state; ir_we is masked by reset so reset wins over imem_valid.
  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    reg_we    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (r_state)
      S_FETCH: ir_we = imem_valid & resetl;
      S_EXEC: begin
        if (r_ctrl.cls == CLS_B) begin
          pc_we  = 1'b1;
          pc_src = 1'b1;
        end else if (r_ctrl.cls == CLS_CBZ) begin
          pc_we  = 1'b1;
          pc_src = zero;
        end
      end
      S_MEM: begin
        mem_read  = (r_ctrl.cls == CLS_LDUR);
        mem_write = (r_ctrl.cls == CLS_STUR);
        pc_we     = (r_ctrl.cls == CLS_STUR) && dmem_ready;
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign sign_op    = r_ctrl.signOp;
  assign alu_op     = r_ctrl.aluOp;
  assign alu_src    = r_ctrl.aluSrc;
  assign reg2loc    = r_ctrl.reg2loc;
  assign mem_to_reg = (r_ctrl.cls == CLS_LDUR);
  assign fault      = (r_state == S_FAULT);
  assign state      = r_state;

endmodule
